// File: rtl/ir_packet_sm_if.sv
// Request/status bundle between the packet-rate logic and the IR packet framer.
interface ir_packet_sm_if;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic       IR_LED;
    logic       BUSY;
    logic       DONE;

    modport master (output SEND_PACKET, output COMMAND, input IR_LED, input BUSY, input DONE);
    modport slave  (input SEND_PACKET, input COMMAND, output IR_LED, output BUSY, output DONE);
endinterface

// File: rtl/ir_packet_sm.sv
// IR control-packet framer: start, car-select and four command bursts, each
// followed by a gap, with bursts gated by an internally generated carrier.
module ir_packet_sm #(
    parameter int CARRIER_HALF    = 1389,
    parameter int CARRIER_W       = 12,
    parameter int START_PULSES    = 191,
    parameter int GAP_PULSES      = 25,
    parameter int SELECT_PULSES   = 47,
    parameter int ASSERT_PULSES   = 47,
    parameter int DEASSERT_PULSES = 22,
    parameter int PULSE_W         = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    ir_packet_sm_if.slave  pkt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_GAP    = 3'd2,
        ST_SELECT = 3'd3,
        ST_CMD    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_START  = 2'd0,
        SRC_SELECT = 2'd1,
        SRC_CMD    = 2'd2
    } gap_src_t;

    localparam logic [CARRIER_W-1:0] CARRIER_MAX   = CARRIER_W'(2 * CARRIER_HALF - 1);
    localparam logic [CARRIER_W-1:0] CARRIER_HALFC = CARRIER_W'(CARRIER_HALF);
    localparam logic [PULSE_W-1:0]   START_LAST    = PULSE_W'(START_PULSES - 1);
    localparam logic [PULSE_W-1:0]   GAP_LAST      = PULSE_W'(GAP_PULSES - 1);
    localparam logic [PULSE_W-1:0]   SELECT_LAST   = PULSE_W'(SELECT_PULSES - 1);
    localparam logic [PULSE_W-1:0]   ASSERT_LAST   = PULSE_W'(ASSERT_PULSES - 1);
    localparam logic [PULSE_W-1:0]   DEASSERT_LAST = PULSE_W'(DEASSERT_PULSES - 1);

    state_t                 state_r, state_nxt_s;
    gap_src_t               gap_src_r, gap_src_nxt_s;
    logic [1:0]             idx_r, idx_nxt_s;
    logic [3:0]             cmd_r, cmd_nxt_s;
    logic [CARRIER_W-1:0]   carrier_r, carrier_nxt_s;
    logic [PULSE_W-1:0]     pulse_r, pulse_nxt_s;
    logic                   ir_led_r, ir_led_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   wrap_s, last_s, cmd_bit_s;
    logic [PULSE_W-1:0]     target_last_s;

    // CMD[i] carries COMMAND bit 3-i so the order on air is RIGHT, LEFT, BACKWARD, FORWARD
    assign cmd_bit_s = cmd_r[2'd3 - idx_r];
    assign wrap_s    = (carrier_r == CARRIER_MAX);
    assign last_s    = wrap_s && (pulse_r == target_last_s);

    // Period count at which the current state ends
    always_comb begin
        target_last_s = START_LAST;
        case (state_r)
            ST_START:  target_last_s = START_LAST;
            ST_GAP:    target_last_s = GAP_LAST;
            ST_SELECT: target_last_s = SELECT_LAST;
            ST_CMD:    target_last_s = cmd_bit_s ? ASSERT_LAST : DEASSERT_LAST;
            default:   target_last_s = START_LAST;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            gap_src_r <= SRC_START;
            idx_r     <= 2'd0;
            cmd_r     <= 4'd0;
            carrier_r <= '0;
            pulse_r   <= '0;
            ir_led_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gap_src_r <= gap_src_nxt_s;
            idx_r     <= idx_nxt_s;
            cmd_r     <= cmd_nxt_s;
            carrier_r <= carrier_nxt_s;
            pulse_r   <= pulse_nxt_s;
            ir_led_r  <= ir_led_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Next-state, counter and sequencing logic
    always_comb begin
        state_nxt_s   = state_r;
        gap_src_nxt_s = gap_src_r;
        idx_nxt_s     = idx_r;
        cmd_nxt_s     = cmd_r;
        carrier_nxt_s = carrier_r;
        pulse_nxt_s   = pulse_r;
        if (state_r == ST_IDLE) begin
            carrier_nxt_s = '0;
            pulse_nxt_s   = '0;
            if (pkt.SEND_PACKET) begin
                state_nxt_s = ST_START;
                cmd_nxt_s   = pkt.COMMAND;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            carrier_nxt_s = wrap_s ? '0 : carrier_r + CARRIER_W'(1);
            if (last_s) begin
                pulse_nxt_s = '0;
                case (state_r)
                    ST_START: begin
                        state_nxt_s   = ST_GAP;
                        gap_src_nxt_s = SRC_START;
                    end
                    ST_SELECT: begin
                        state_nxt_s   = ST_GAP;
                        gap_src_nxt_s = SRC_SELECT;
                    end
                    ST_CMD: begin
                        state_nxt_s   = ST_GAP;
                        gap_src_nxt_s = SRC_CMD;
                    end
                    ST_GAP: begin
                        case (gap_src_r)
                            SRC_START:  state_nxt_s = ST_SELECT;
                            SRC_SELECT: begin
                                state_nxt_s = ST_CMD;
                                idx_nxt_s   = 2'd0;
                            end
                            SRC_CMD: begin
                                if (idx_r == 2'd3) begin
                                    state_nxt_s = ST_IDLE;
                                    idx_nxt_s   = 2'd0;
                                end else begin
                                    state_nxt_s = ST_CMD;
                                    idx_nxt_s   = idx_r + 2'd1;
                                end
                            end
                            default:    state_nxt_s = ST_IDLE;
                        endcase
                    end
                    default: state_nxt_s = ST_IDLE;
                endcase
            end else if (wrap_s) begin
                pulse_nxt_s = pulse_r + PULSE_W'(1);
            end else begin
                pulse_nxt_s = pulse_r;
            end
        end
    end

    // Outputs are precomputed from next-state values so they register with no added latency
    always_comb begin
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        ir_led_nxt_s = ((state_nxt_s == ST_START) || (state_nxt_s == ST_SELECT) ||
                        (state_nxt_s == ST_CMD)) && (carrier_nxt_s < CARRIER_HALFC);
        done_nxt_s   = (state_r == ST_GAP) && (gap_src_r == SRC_CMD) &&
                       (idx_r == 2'd3) && last_s;
    end

    assign pkt.IR_LED = ir_led_r;
    assign pkt.BUSY   = busy_r;
    assign pkt.DONE   = done_r;

endmodule

// File: doc/ir_packet_sm.md
# ir_packet_sm

Packet-framing state machine for the IR transmitter, directly downstream of the 10 Hz packet-rate counter. Each single-cycle SEND_PACKET pulse starts one IR control packet for the car: start burst, car-select burst, then four command bursts (RIGHT, LEFT, BACKWARD, FORWARD), each followed by a gap. Bursts are gated by a carrier generated internally from CLK. IR_LED drives the board's IR LED pin directly.

## Interface
- CARRIER_HALF, 1389: CLK cycles per carrier half-period (100 MHz / 36 kHz / 2).
- CARRIER_W, 12: carrier counter width; must hold 2*CARRIER_HALF-1.
- START_PULSES, 191: carrier periods in start burst.
- GAP_PULSES, 25: carrier periods in every gap.
- SELECT_PULSES, 47: carrier periods in car-select burst.
- ASSERT_PULSES, 47: carrier periods in a command burst whose bit is 1.
- DEASSERT_PULSES, 22: carrier periods in a command burst whose bit is 0.
- PULSE_W, 8: pulse counter width; all pulse parameters are in 1..2^PULSE_W-1.
- CLK  in  1  system clock.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- SEND_PACKET  in  1  single-cycle start request.
- COMMAND  in  4  [3]=RIGHT, [2]=LEFT, [1]=BACKWARD, [0]=FORWARD.
- IR_LED  out  1  modulated IR output.
- BUSY  out  1  high while a packet is in progress.
- DONE  out  1  one-cycle pulse when a packet completes.

## Operation
- States: IDLE, START, GAP, SELECT, CMD. A 2-bit index (0..3) selects the command bit in CMD; a flag records whether a GAP follows START, SELECT or a CMD.
- Flow: IDLE -> START -> GAP -> SELECT -> GAP -> CMD[0] -> GAP -> CMD[1] -> GAP -> CMD[2] -> GAP -> CMD[3] -> GAP -> IDLE. CMD[i] transmits COMMAND bit 3-i, in the order RIGHT, LEFT, BACKWARD, FORWARD.
- Acceptance: SEND_PACKET is sampled only in IDLE. On acceptance, COMMAND is latched, the carrier counter and pulse counter clear, and the state goes to START. SEND_PACKET is ignored in every other state, with no queuing.
- Carrier counter: counts 0..2*CARRIER_HALF-1 and wraps, running only outside IDLE. Each wrap completes one carrier period and increments the pulse counter.
- A state ends on the wrap that completes its Nth period, where N is that state's parameter; CMD uses ASSERT_PULSES or DEASSERT_PULSES depending on its latched bit. The pulse counter clears on every state change.
- IR_LED = (state is START, SELECT or CMD) AND (carrier count < CARRIER_HALF). It is decoded from registers only. IR_LED is 0 in GAP and IDLE.
- BUSY = (state != IDLE).
- DONE: registered; high for exactly the first IDLE cycle after the final GAP.
- Reset: on a cycle with RESET=1, the next state is IDLE and all counters, the index and the latched command clear. IR_LED=0, BUSY=0, DONE=0. RESET overrides SEND_PACKET in the same cycle and aborts a packet mid-flight with no DONE.

## Timing
- If SEND_PACKET=1 in IDLE at edge t: BUSY=1 and IR_LED=1 from cycle t+1.
- Each burst starts high: CARRIER_HALF cycles high, then CARRIER_HALF cycles low, per period.
- Packet length in CLK cycles = 2*CARRIER_HALF*(START + SELECT + 6*GAP + sum of four command-burst lengths), where each command-burst length is ASSERT_PULSES or DEASSERT_PULSES.
- After the last GAP cycle, the next cycle is IDLE with BUSY=0 and DONE=1. A SEND_PACKET in that cycle is accepted, so back-to-back packets have exactly one IDLE cycle between them.
- COMMAND changes after acceptance have no effect on the packet in flight.

## Test plan
Unless noted, use CARRIER_HALF=2, START=3, GAP=2, SELECT=2, ASSERT=3, DEASSERT=1.
- Reset: assert RESET for 3 cycles, then release -> IR_LED=0, BUSY=0, DONE=0; with no SEND_PACKET, all outputs stay 0 for 200 cycles.
- COMMAND=4'b0000, pulse SEND -> BUSY high for exactly 84 cycles; 9 IR_LED rising edges; each high phase lasts 2 cycles; DONE pulses once, in the cycle BUSY falls.
- COMMAND=4'b1111 -> BUSY high for 116 cycles; 17 IR_LED rising edges. COMMAND=4'b1010 -> BUSY high for 100 cycles; the command bursts contain 3, 1, 3 and 1 periods respectively.
- Command latching: SEND with 4'b0000, then drive COMMAND=4'b1111 one cycle later -> packet identical to the 4'b0000 case. A SEND_PACKET pulsed mid-packet is ignored: the packet ends at the same cycle and no second packet starts.
- Back-to-back: pulse SEND again in the DONE cycle -> the second packet starts on the next cycle; exactly one cycle with BUSY=0 separates the packets.
- Reset mid-packet: assert RESET during the SELECT burst -> next cycle IDLE, IR_LED=0, BUSY=0, no DONE. A SEND_PACKET in the same cycle as RESET is dropped. A later SEND produces a full, correct packet.
